// File: rtl/apb_keypad_scanner.sv
// APB-attached matrix keypad scanner: row-by-row drive, per-key debounce,
// press/release event FIFO with overflow flag and level interrupt.
module apb_keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [3:0]      PADDR,
  input  logic [31:0]     PWDATA,
  output logic [31:0]     PRDATA,
  output logic            PREADY,
  output logic            PSLVERR,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row,
  output logic            irq
);

  localparam int NKEYS       = ROWS * COLS;
  localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW          = $clog2(SCAN_DIV);
  localparam int PW          = $clog2(FIFO_DEPTH);
  localparam int SETTLE_LAST = SCAN_DIV - COLS - 2;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_PROC} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [COLS-1:0] snap_q, snap_d;
  logic [NKEYS-1:0] keys_q, keys_d;
  logic [3:0]      deb_q [NKEYS];
  logic [3:0]      deb_d [NKEYS];
  logic [1:0]      ctrl_q, ctrl_d;
  logic [4:0]      fifo_q [FIFO_DEPTH];
  logic [4:0]      fifo_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            irq_q, irq_d;

  logic        wr_ctrl, wr_isr, rd_evt;
  logic        fifo_empty, fifo_full, pop, push, do_push;
  logic [4:0]  push_data, head;
  logic        unused_pwdata;

  assign PREADY        = 1'b1;
  assign PSLVERR       = 1'b0;
  assign irq           = irq_q;
  assign unused_pwdata = ^PWDATA[31:2];

  assign wr_ctrl    = PSEL & PENABLE & PWRITE & (PADDR == 4'h8);
  assign wr_isr     = PSEL & PENABLE & PWRITE & (PADDR == 4'hC);
  assign rd_evt     = PSEL & PENABLE & ~PWRITE & (PADDR == 4'h4);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pop        = rd_evt & ~fifo_empty;
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    row = '1;
    if (state_q != S_IDLE) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (row_idx_q == RW'(r)) row[r] = 1'b0;
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      unique case (PADDR)
        4'h0: PRDATA[NKEYS-1:0] = keys_q;
        4'h4: if (!fifo_empty) PRDATA[8:0] = {1'b1, head[4], 3'b000, head[3:0]};
        4'h8: PRDATA[1:0] = ctrl_q;
        4'hC: PRDATA[1:0] = {ovf_q, ~fifo_empty};
        default: PRDATA = '0;
      endcase
    end
  end

  // Scan FSM and debounce; a disable written this cycle takes precedence
  // over processing so nothing is pushed on the way into IDLE.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    keys_d    = keys_q;
    deb_d     = deb_q;
    push      = 1'b0;
    push_data = '0;
    ctrl_d    = wr_ctrl ? PWDATA[1:0] : ctrl_q;

    if (!ctrl_d[0]) begin
      state_d   = S_IDLE;
      row_idx_d = '0;
      cnt_d     = '0;
      for (int unsigned k = 0; k < NKEYS; k++) deb_d[k] = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d   = S_SETTLE;
          row_idx_d = '0;
          cnt_d     = '0;
        end
        S_SETTLE: begin
          if (cnt_q == CW'(SETTLE_LAST)) begin
            state_d = S_SAMPLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SAMPLE: begin
          snap_d  = ~col_in;
          state_d = S_PROC;
          cnt_d   = '0;
        end
        S_PROC: begin
          for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
              if (row_idx_q == RW'(r) && cnt_q == CW'(c)) begin
                if (snap_q[c] == keys_q[r*COLS+c]) begin
                  deb_d[r*COLS+c] = '0;
                end else if (deb_q[r*COLS+c] == 4'(DEBOUNCE - 1)) begin
                  keys_d[r*COLS+c] = ~keys_q[r*COLS+c];
                  deb_d[r*COLS+c]  = '0;
                  push             = 1'b1;
                  push_data        = {~keys_q[r*COLS+c], 4'(r*COLS+c)};
                end else begin
                  deb_d[r*COLS+c] = deb_q[r*COLS+c] + 4'd1;
                end
              end
            end
          end
          if (cnt_q == CW'(COLS - 1)) begin
            state_d   = S_SETTLE;
            cnt_d     = '0;
            row_idx_d = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + RW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push  = push & (~fifo_full | pop);
    if (do_push) begin
      fifo_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr_isr && PWDATA[1]) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    irq_d = ctrl_q[1] & (~fifo_empty | ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_idx_q <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      keys_q    <= '0;
      for (int unsigned k = 0; k < NKEYS; k++) deb_q[k] <= '0;
      ctrl_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      keys_q    <= keys_d;
      deb_q     <= deb_d;
      ctrl_q    <= ctrl_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_apb_keypad_scanner.sv
// Directed bench for apb_keypad_scanner (4x4, SCAN_DIV=8, DEBOUNCE=2, FIFO_DEPTH=4).
module tb_apb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [3:0]  col_in, row;
  logic        irq;
  logic [15:0] keys_down;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  apb_keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .col_in(col_in), .row(row), .irq(irq)
  );

  // Keypad model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys_down[r*4+c]) col_in[c] = 1'b0;
  end

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge clk); @(negedge clk);
    PENABLE = 1'b1;
    @(posedge clk); @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [3:0] a, output logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge clk); @(negedge clk);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(posedge clk); @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  er;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    keys_down = '0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    check("reset_row", {28'b0, row}, 32'hF);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("pready", {31'b0, PREADY}, 32'h1);
    check("pslverr", {31'b0, PSLVERR}, 32'h0);

    // Register map vectors
    tbl[0]  = '{1'b0, 4'h0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 4'h4, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 4'h8, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 4'hC, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 4'h8, 32'hFFFFFFFE, 32'h0};
    tbl[5]  = '{1'b0, 4'h8, 32'h0,        32'h2};
    tbl[6]  = '{1'b0, 4'h2, 32'h0,        32'h0};
    tbl[7]  = '{1'b1, 4'h0, 32'h0000FFFF, 32'h0};
    tbl[8]  = '{1'b0, 4'h0, 32'h0,        32'h0};
    tbl[9]  = '{1'b0, 4'hF, 32'h0,        32'h0};
    tbl[10] = '{1'b1, 4'h8, 32'h0,        32'h0};
    tbl[11] = '{1'b0, 4'h8, 32'h0,        32'h0};
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) apb_wr(tbl[i].addr, tbl[i].wdata);
      else begin
        apb_rd(tbl[i].addr, d);
        check($sformatf("regvec%0d", i), d, tbl[i].exp);
      end
    end
    apb_wr(4'h8, 32'h2);
    PADDR = 4'h8;
    #1 check("prdata_nosel", PRDATA, 32'h0);
    apb_wr(4'h8, 32'h0);

    // Free-running scan with no keys
    do_reset();
    apb_wr(4'h8, 32'h3);
    for (int k = 0; k < 33; k++) begin
      er = ~(4'b0001 << ((k / 8) % 4));
      check($sformatf("scan_row_c%0d", k), {28'b0, row}, {28'b0, er});
      wait_cyc(1);
    end
    check("scan_irq", {31'b0, irq}, 32'h0);
    apb_rd(4'hC, d);
    check("scan_isr", d, 32'h0);

    // Key (1,2) held for three row-1 slots
    do_reset();
    keys_down = 16'h0040;
    apb_wr(4'h8, 32'h3);
    wait_cyc(30);
    apb_rd(4'hC, d);
    check("press_isr_slot1", d, 32'h0);
    wait_cyc(30);
    apb_rd(4'hC, d);
    check("press_isr_slot2", d, 32'h1);
    wait_cyc(32);
    check("press_irq", {31'b0, irq}, 32'h1);
    apb_wr(4'h8, 32'h2);
    apb_rd(4'h0, d);
    check("press_keys", d, 32'h40);
    apb_rd(4'h4, d);
    check("press_event", d, 32'h186);
    apb_rd(4'h4, d);
    check("press_event_empty", d, 32'h0);

    // Single-slot bounce
    do_reset();
    keys_down = 16'h0040;
    apb_wr(4'h8, 32'h1);
    wait_cyc(32);
    keys_down = '0;
    wait_cyc(64);
    apb_wr(4'h8, 32'h0);
    apb_rd(4'hC, d);
    check("bounce_isr", d, 32'h0);
    apb_rd(4'h0, d);
    check("bounce_keys", d, 32'h0);

    // Six flips into a four-deep FIFO
    do_reset();
    keys_down = 16'h8463;
    apb_wr(4'h8, 32'h3);
    wait_cyc(64);
    apb_wr(4'h8, 32'h2);
    apb_rd(4'hC, d);
    check("ovf_isr", d, 32'h3);
    check("ovf_irq", {31'b0, irq}, 32'h1);
    apb_rd(4'h0, d);
    check("ovf_keys", d, 32'h8463);
    apb_wr(4'hC, 32'h2);
    apb_rd(4'hC, d);
    check("ovf_cleared", d, 32'h1);
    apb_rd(4'h4, d); check("ovf_ev0", d, 32'h180);
    apb_rd(4'h4, d); check("ovf_ev1", d, 32'h181);
    apb_rd(4'h4, d); check("ovf_ev2", d, 32'h185);
    apb_rd(4'h4, d); check("ovf_ev3", d, 32'h186);
    apb_rd(4'h4, d); check("ovf_ev4_empty", d, 32'h0);
    apb_rd(4'hC, d);
    check("ovf_isr_end", d, 32'h0);

    // Disable mid-PROC of row 1 after key (1,2) was counted once
    do_reset();
    keys_down = 16'h0001;
    apb_wr(4'h8, 32'h1);
    wait_cyc(64);
    keys_down = 16'h0041;
    wait_cyc(14);
    apb_wr(4'h8, 32'h0);
    check("dis_row", {28'b0, row}, 32'hF);
    apb_rd(4'h0, d);
    check("dis_keys", d, 32'h1);
    apb_rd(4'hC, d);
    check("dis_isr", d, 32'h1);
    apb_wr(4'h8, 32'h1);
    wait_cyc(32);
    apb_wr(4'h8, 32'h0);
    apb_rd(4'h0, d);
    check("dis_keys_after", d, 32'h1);
    apb_rd(4'h4, d);
    check("dis_event", d, 32'h180);
    apb_rd(4'h4, d);
    check("dis_event_empty", d, 32'h0);

    // Reset with two events queued, mid-PROC
    do_reset();
    keys_down = 16'h0003;
    apb_wr(4'h8, 32'h3);
    wait_cyc(64);
    check("rst_pre_irq", {31'b0, irq}, 32'h1);
    wait_cyc(4);
    do_reset();
    check("rst_row", {28'b0, row}, 32'hF);
    check("rst_irq", {31'b0, irq}, 32'h0);
    apb_rd(4'h4, d);
    check("rst_event", d, 32'h0);
    apb_rd(4'h0, d);
    check("rst_keys", d, 32'h0);
    apb_rd(4'h8, d);
    check("rst_ctrl", d, 32'h0);
    apb_rd(4'hC, d);
    check("rst_isr", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
